// File: rtl/onehot_state_reg_if.sv
// onehot_state_reg_if: load/status bundle between FSM next-state logic and the one-hot state register
interface onehot_state_reg_if #(
    parameter int N       = 6,
    parameter int DWELL_W = 8
);
    localparam int IW = $clog2(N);
    logic               en;
    logic [N-1:0]       nxt_state;
    logic               err_clr;
    logic [N-1:0]       state;
    logic [IW-1:0]      state_idx;
    logic               changed;
    logic [DWELL_W-1:0] dwell;
    logic               err;
    modport master (output en, nxt_state, err_clr, input state, state_idx, changed, dwell, err);
    modport slave  (input en, nxt_state, err_clr, output state, state_idx, changed, dwell, err);
endinterface

// File: rtl/onehot_state_reg.sv
// onehot_state_reg: one-hot state register with binary index, change pulse and saturating dwell counter.
// Define ONEHOT_SAFE_EN to replace illegal next-state vectors with the reset state and flag a sticky err.
module onehot_state_reg #(
    parameter int N         = 6,
    parameter int RESET_IDX = 0,
    parameter int DWELL_W   = 8
) (
    input logic                     clk,
    input logic                     rst,
    onehot_state_reg_if.slave       bus
);
    localparam int IW = $clog2(N);
    localparam logic [N-1:0] RESET_VEC = N'(1) << RESET_IDX;
    logic [N-1:0]       load_val;
    logic [IW-1:0]      load_idx;
    logic [DWELL_W-1:0] dwell_inc;
    logic               diff;
`ifdef ONEHOT_SAFE_EN
    logic legal;
    assign legal    = (|bus.nxt_state) & ~|(bus.nxt_state & (bus.nxt_state - N'(1)));
    assign load_val = legal ? bus.nxt_state : RESET_VEC;
    // a same-cycle illegal load wins over err_clr
    always_ff @(posedge clk)
        bus.err <= rst ? 1'b0 : (bus.en & ~legal) | (bus.err & ~bus.err_clr);
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign load_val       = bus.nxt_state;
    assign bus.err        = 1'b0;
`endif
    // index of the lowest set bit of the value being loaded, 0 when none
    always_comb begin
        load_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (load_val[i]) load_idx = IW'(i);
    end
    assign diff      = load_val != bus.state;
    assign dwell_inc = &bus.dwell ? bus.dwell : bus.dwell + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.state     <= RESET_VEC;
            bus.state_idx <= IW'(RESET_IDX);
            bus.changed   <= 1'b0;
            bus.dwell     <= '0;
        end else if (bus.en) begin
            bus.state     <= load_val;
            bus.state_idx <= load_idx;
            bus.changed   <= diff;
            bus.dwell     <= diff ? '0 : dwell_inc;
        end else begin
            bus.changed   <= 1'b0;
            bus.dwell     <= dwell_inc;
        end
    end
endmodule

// File: doc/onehot_state_reg.md
# onehot_state_reg

Parametrised one-hot state register for FSM datapaths: holds an N-bit one-hot state vector, loads the next state under an enable, and reports the binary index, a state-change pulse and a dwell-time counter. It replaces the fixed 6-bit asynchronously reset state register with a synchronous, active-high reset that is configurable in width and reset state. An optional protection feature rejects illegal next-state vectors. The block sits between an FSM's next-state logic and its output decode.

## Interface
- N, 6: number of states and one-hot vector width; N ≥ 2.
- RESET_IDX, 0: index of the bit set on reset; 0 ≤ RESET_IDX < N.
- DWELL_W, 8: width of the dwell counter.
- IW (localparam) = $clog2(N): index width.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  load enable for nxt_state.
- nxt_state  in  N  proposed next state (from next-state logic).
- ERR_CLR  in  1  clears sticky ERR.
- state  out  N  current one-hot state.
- state_idx  out  IW  binary index of the set bit in state.
- changed  out  1  one-cycle pulse on the first cycle of a new state.
- dwell  out  DWELL_W  completed cycles spent in the current state, saturating.
- ERR  out  1  sticky illegal-next-state flag.

## Operation
- Priority: RST > load/hold logic. ERR set > ERR_CLR.
- Reset (RST=1 at edge):
  - state = 1<<RESET_IDX; state_idx = RESET_IDX.
  - changed = 0, dwell = 0, ERR = 0.
  - Takes effect mid-operation, regardless of EN.
- Hold (EN=0):
  - state and state_idx are unchanged; changed = 0.
  - dwell increments by 1 and saturates at 2^DWELL_W−1 (no wrap).
- Legal load (EN=1, nxt_state has exactly one bit set):
  - state ← nxt_state; state_idx ← index of that bit.
  - If nxt_state ≠ state: changed = 1 and dwell = 0.
  - If nxt_state = state (self-loop): changed = 0 and dwell increments, saturating.
- Illegal load (EN=1, nxt_state zero or multi-hot): behaviour depends on ONEHOT_SAFE_EN (see Configuration).
- ERR_CLR=1 clears ERR at the edge unless an illegal load occurs in the same cycle, in which case ERR stays 1.
- state_idx is computed from the value being loaded, not from the registered state, so it has no extra lag.

## Timing
- Every output is registered, with 1-cycle latency from EN/nxt_state to state, state_idx, changed and dwell.
- changed is high for exactly the first cycle on which the new state is visible.
- dwell reads 0 on the first cycle in a state, 1 on the second, and so on.
- Back-to-back loads to different states every cycle: changed stays high continuously and dwell stays 0.
- RST deasserted: the first load is accepted at the next edge at which EN=1.

## Configuration
- Macro: ONEHOT_SAFE_EN.
- Defined (illegal load):
  - state ← 1<<RESET_IDX and state_idx ← RESET_IDX.
  - changed and dwell follow the legal-load rules, comparing against the recovered vector.
  - ERR ← 1 (sticky).
- Undefined (illegal load):
  - nxt_state is loaded raw; state_idx = index of the lowest set bit, or 0 for an all-zero vector.
  - changed = 1 if nxt_state ≠ state.
  - ERR is tied to 0 and ERR_CLR is ignored.

## Test plan
- Reset: N=6, RESET_IDX=0, hold RST=1 for 2 cycles with EN=1 and nxt_state=6'b000100 → state=6'b000001, state_idx=0, changed=0, dwell=0, ERR=0.
- Sequential walk: EN=1 with nxt_state 000010, 000100, 100000 on consecutive cycles → state follows one cycle later; state_idx = 1, 2, 5; changed=1 on each of those three cycles.
- Dwell saturation: DWELL_W=4, EN=0 for 20 cycles after a load → dwell counts 0..15 and then holds at 15. A self-loop load (EN=1, nxt_state=state) keeps incrementing dwell with changed=0.
- Illegal load with ONEHOT_SAFE_EN defined: state=000100, EN=1, nxt_state=001100 → state=000001, changed=1, dwell=0, ERR=1. ERR stays 1 on later legal loads until ERR_CLR is pulsed.
- Simultaneous ERR set and clear (ONEHOT_SAFE_EN defined): ERR_CLR=1 in the same cycle as an illegal load of nxt_state=000000 → ERR=1. ERR_CLR=1 on the next cycle with a legal load → ERR=0.
- Without ONEHOT_SAFE_EN: nxt_state=001100 → state=001100, state_idx=2, ERR=0. nxt_state=000000 → state=000000, state_idx=0.
